// File: rtl/swo_uart_rx.sv
// swo_uart_rx
//   Asynchronous SWO (NRZ/UART 8N1) receiver running on trace_clk. The raw
//   swo line is synchronised, a falling edge starts a frame, and each bit is
//   sampled near its centre by a down-counting bit timer. Recovered bytes
//   (LSB first) are presented on a one-entry valid/ready output register.
//
// Ports
//   trace_clk        in   sole clock
//   reset            in   async, active-high; clears all state
//   swo              in   raw SWO line, asynchronous, idles high
//   I_enable         in   0 forces IDLE and ignores the line
//   I_baud_div       in   clocks per bit minus 1 (values < 3 treated as 3)
//   O_data           out  received byte
//   O_data_valid     out  byte held in O_data
//   I_data_ready     in   consumer accepts byte when valid & ready
//   O_framing_error  out  1-cycle pulse: stop bit sampled low
//   O_overrun        out  1-cycle pulse: byte completed while output full
//   O_busy           out  receiver FSM not in IDLE
module swo_uart_rx #(
  parameter int unsigned pDIV_WIDTH   = 8,
  parameter int unsigned pSYNC_STAGES = 2
) (
  input  logic                  trace_clk,
  input  logic                  reset,
  input  logic                  swo,
  input  logic                  I_enable,
  input  logic [pDIV_WIDTH-1:0] I_baud_div,
  output logic [7:0]            O_data,
  output logic                  O_data_valid,
  input  logic                  I_data_ready,
  output logic                  O_framing_error,
  output logic                  O_overrun,
  output logic                  O_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [pSYNC_STAGES-1:0] r_sync;
  logic                    r_swo_prev;
  logic [1:0]              r_state;
  logic [pDIV_WIDTH-1:0]   r_timer;
  logic [pDIV_WIDTH-1:0]   r_div;
  logic [2:0]              r_bitcnt;
  logic [7:0]              r_shift;
  logic [7:0]              r_data;
  logic                    r_valid;
  logic                    r_ferr;
  logic                    r_ovr;

  logic                    w_swo_s;
  logic                    w_fall;
  logic                    w_sample;
  logic [pDIV_WIDTH-1:0]   w_div_eff;
  logic                    w_stop_sample;
  logic                    w_good;
  logic                    w_bad;
  logic                    w_drain;

  // Synchroniser presets to 1 (line idle) so reset release never looks like
  // a start edge.
  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[pSYNC_STAGES-2:0], swo};
    end
  end

  assign w_swo_s       = r_sync[pSYNC_STAGES-1];
  assign w_fall        = r_swo_prev & ~w_swo_s;
  assign w_sample      = (r_timer == '0);
  assign w_div_eff     = (I_baud_div < pDIV_WIDTH'(3)) ? pDIV_WIDTH'(3) : I_baud_div;
  assign w_stop_sample = I_enable && (r_state == S_STOP) && w_sample;
  assign w_good        = w_stop_sample &  w_swo_s;
  assign w_bad         = w_stop_sample & ~w_swo_s;
  assign w_drain       = r_valid & I_data_ready;

  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      r_swo_prev <= 1'b1;
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_div      <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
    end else begin
      // Tracked in every state so a held-low line (break) needs a fresh
      // high-to-low transition before another frame is accepted.
      r_swo_prev <= w_swo_s;
      if (!I_enable) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_fall) begin
              r_div   <= w_div_eff;
              r_timer <= w_div_eff >> 1;
              r_state <= S_START;
            end
          end
          S_START: begin
            if (w_sample) begin
              if (w_swo_s) begin
                r_state <= S_IDLE;
              end else begin
                r_timer  <= r_div;
                r_bitcnt <= '0;
                r_state  <= S_DATA;
              end
            end else begin
              r_timer <= r_timer - pDIV_WIDTH'(1);
            end
          end
          S_DATA: begin
            if (w_sample) begin
              // Right shift: after eight samples the first bit sits in bit 0.
              r_shift <= {w_swo_s, r_shift[7:1]};
              r_timer <= r_div;
              if (r_bitcnt == 3'd7) begin
                r_state <= S_STOP;
              end else begin
                r_bitcnt <= r_bitcnt + 3'd1;
              end
            end else begin
              r_timer <= r_timer - pDIV_WIDTH'(1);
            end
          end
          default: begin
            if (w_sample) begin
              r_state <= S_IDLE;
            end else begin
              r_timer <= r_timer - pDIV_WIDTH'(1);
            end
          end
        endcase
      end
    end
  end

  // One-entry output register; a byte arriving during a drain replaces the
  // accepted one without a gap in valid.
  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_bad;
      r_ovr  <= 1'b0;
      if (w_good && (!r_valid || I_data_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else begin
        if (w_good) begin
          r_ovr <= 1'b1;
        end
        if (w_drain) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign O_data          = r_data;
  assign O_data_valid    = r_valid;
  assign O_framing_error = r_ferr;
  assign O_overrun       = r_ovr;
  assign O_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_swo_uart_rx.sv
module tb_swo_uart_rx;

  localparam int SYNC = 2;

  logic       trace_clk = 1'b0;
  logic       reset;
  logic       swo;
  logic       I_enable;
  logic [7:0] I_baud_div;
  logic [7:0] O_data;
  logic       O_data_valid;
  logic       I_data_ready;
  logic       O_framing_error;
  logic       O_overrun;
  logic       O_busy;

  swo_uart_rx #(.pDIV_WIDTH(8), .pSYNC_STAGES(SYNC)) dut (
    .trace_clk       (trace_clk),
    .reset           (reset),
    .swo             (swo),
    .I_enable        (I_enable),
    .I_baud_div      (I_baud_div),
    .O_data          (O_data),
    .O_data_valid    (O_data_valid),
    .I_data_ready    (I_data_ready),
    .O_framing_error (O_framing_error),
    .O_overrun       (O_overrun),
    .O_busy          (O_busy)
  );

  always #5 trace_clk = ~trace_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge trace_clk) cyc++;

  // Observed consumer-side events
  logic [7:0] rx_q[$];
  int  fe_cnt    = 0;
  int  ov_cnt    = 0;
  int  busy_hi   = 0;
  int  rise_cyc  = -1;
  int  start_cyc = 0;
  logic prev_valid = 1'b0;

  always @(negedge trace_clk) begin
    if (O_data_valid && I_data_ready) rx_q.push_back(O_data);
    if (O_framing_error) fe_cnt++;
    if (O_overrun) ov_cnt++;
    if (O_busy) busy_hi++;
    if (O_data_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = O_data_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge trace_clk);
      #1;
    end
  endtask

  function automatic int deff(input int d);
    return (d < 3) ? 3 : d;
  endfunction

  // Cycles from driving the start edge to valid rising: synchroniser, one
  // cycle to see the edge, one to act on the loaded half-bit count reaching
  // zero, the half bit itself, then nine full bit periods to the stop sample.
  function automatic int exp_latency(input int d);
    int e;
    e = deff(d);
    return SYNC + 2 + (e / 2) + 9 * (e + 1);
  endfunction

  // Drives start bit, nbits data bits (LSB first) and optionally the stop bit.
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit with_stop,
                           input logic stopb, input int P);
    swo = 1'b0;
    start_cyc = cyc;
    tick(P);
    for (int i = 0; i < nbits; i++) begin
      swo = b[i];
      tick(P);
    end
    if (with_stop) begin
      swo = stopb;
      tick(P);
      swo = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb, input int d);
    I_baud_div = 8'(d);
    send_bits(b, 8, 1'b1, stopb, deff(d) + 1);
  endtask

  task automatic clear_obs();
    rx_q.delete();
    fe_cnt   = 0;
    ov_cnt   = 0;
    busy_hi  = 0;
    rise_cyc = -1;
  endtask

  typedef struct {
    int         div;
    logic [7:0] data;
    logic       stopb;
    int         exp_nbytes;
    int         exp_fe;
  } vec_t;

  vec_t vecs[8];

  logic [7:0] exp_q[$];
  int exp_fe;

  initial begin
    vecs[0] = '{div: 3,   data: 8'hA5, stopb: 1'b1, exp_nbytes: 1, exp_fe: 0};
    vecs[1] = '{div: 7,   data: 8'h3C, stopb: 1'b0, exp_nbytes: 0, exp_fe: 1};
    vecs[2] = '{div: 1,   data: 8'h5A, stopb: 1'b1, exp_nbytes: 1, exp_fe: 0};
    vecs[3] = '{div: 0,   data: 8'hC3, stopb: 1'b1, exp_nbytes: 1, exp_fe: 0};
    vecs[4] = '{div: 15,  data: 8'h81, stopb: 1'b1, exp_nbytes: 1, exp_fe: 0};
    vecs[5] = '{div: 4,   data: 8'h7E, stopb: 1'b1, exp_nbytes: 1, exp_fe: 0};
    vecs[6] = '{div: 255, data: 8'h01, stopb: 1'b1, exp_nbytes: 1, exp_fe: 0};
    vecs[7] = '{div: 10,  data: 8'hFF, stopb: 1'b0, exp_nbytes: 0, exp_fe: 1};

    reset        = 1'b1;
    swo          = 1'b1;
    I_enable     = 1'b1;
    I_data_ready = 1'b1;
    I_baud_div   = 8'd7;
    tick(3);
    check("reset_data",  32'(O_data), 32'h0);
    check("reset_valid", 32'(O_data_valid), 32'h0);
    check("reset_busy",  32'(O_busy), 32'h0);
    check("reset_flags", 32'({O_framing_error, O_overrun}), 32'h0);
    reset = 1'b0;
    clear_obs();
    tick(20);
    check("reset_release_no_start", 32'(busy_hi), 32'h0);

    // Table-driven single frames
    for (int i = 0; i < 8; i++) begin
      clear_obs();
      send_frame(vecs[i].data, vecs[i].stopb, vecs[i].div);
      tick(3);
      check($sformatf("vec%0d_nbytes", i), 32'(rx_q.size()), 32'(vecs[i].exp_nbytes));
      if (vecs[i].exp_nbytes == 1 && rx_q.size() == 1) begin
        check($sformatf("vec%0d_data", i), 32'(rx_q[0]), 32'(vecs[i].data));
        check($sformatf("vec%0d_latency", i), 32'(rise_cyc - start_cyc), 32'(exp_latency(vecs[i].div)));
      end
      check($sformatf("vec%0d_fe", i), 32'(fe_cnt), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_ovr", i), 32'(ov_cnt), 32'h0);
      check($sformatf("vec%0d_valid_idle", i), 32'(O_data_valid), 32'h0);
    end

    // Back-to-back frames, one stop bit
    clear_obs();
    send_frame(8'h00, 1'b1, 15);
    send_frame(8'hFF, 1'b1, 15);
    tick(3);
    check("b2b_nbytes", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      check("b2b_first",  32'(rx_q[0]), 32'h00);
      check("b2b_second", 32'(rx_q[1]), 32'hFF);
    end
    check("b2b_fe", 32'(fe_cnt), 32'h0);

    // Overrun with consumer stalled, then drain
    clear_obs();
    I_data_ready = 1'b0;
    send_frame(8'h11, 1'b1, 7);
    tick(3);
    check("ovr_first_valid", 32'(O_data_valid), 32'h1);
    check("ovr_first_ovr",   32'(ov_cnt), 32'h0);
    send_frame(8'h22, 1'b1, 7);
    tick(3);
    check("ovr_pulse", 32'(ov_cnt), 32'h1);
    check("ovr_hold_data", 32'(O_data), 32'h11);
    check("ovr_hold_valid", 32'(O_data_valid), 32'h1);
    I_data_ready = 1'b1;
    tick(1);
    check("ovr_drain_valid", 32'(O_data_valid), 32'h0);
    check("ovr_drain_nbytes", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() == 1) check("ovr_drain_data", 32'(rx_q[0]), 32'h11);

    // One-clock glitch is a false start
    clear_obs();
    I_baud_div = 8'd7;
    swo = 1'b0;
    tick(1);
    swo = 1'b1;
    tick(12);
    check("glitch_busy_seen", 32'(busy_hi > 0), 32'h1);
    check("glitch_busy_cycles", 32'(busy_hi), 32'd4);
    check("glitch_busy_end", 32'(O_busy), 32'h0);
    check("glitch_nbytes", 32'(rx_q.size()), 32'h0);
    check("glitch_flags", 32'(fe_cnt + ov_cnt), 32'h0);

    // Enable dropped during data bit 4
    clear_obs();
    I_baud_div = 8'd7;
    send_bits(8'hF0, 4, 1'b0, 1'b1, 8);
    tick(4);
    check("abort_en_busy_before", 32'(O_busy), 32'h1);
    I_enable = 1'b0;
    tick(1);
    check("abort_en_busy_after", 32'(O_busy), 32'h0);
    swo = 1'b1;
    tick(20);
    I_enable = 1'b1;
    tick(5);
    check("abort_en_nothing", 32'(rx_q.size() + fe_cnt + ov_cnt), 32'h0);
    send_frame(8'h96, 1'b1, 7);
    tick(3);
    check("abort_en_next_n", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() == 1) check("abort_en_next_data", 32'(rx_q[0]), 32'h96);

    // Reset asserted during data bit 4, with a byte pending in the output
    clear_obs();
    I_data_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 7);
    tick(3);
    check("abort_rst_pending", 32'({O_data_valid, O_data}), 32'h15A);
    send_bits(8'h0F, 4, 1'b0, 1'b1, 8);
    tick(4);
    reset = 1'b1;
    #1;
    check("abort_rst_busy", 32'(O_busy), 32'h0);
    check("abort_rst_out", 32'({O_data_valid, O_data}), 32'h0);
    swo = 1'b1;
    tick(2);
    reset = 1'b0;
    I_data_ready = 1'b1;
    clear_obs();
    tick(20);
    check("abort_rst_idle", 32'(busy_hi + rx_q.size() + fe_cnt), 32'h0);
    send_frame(8'h3C, 1'b1, 5);
    tick(3);
    check("abort_rst_next_n", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() == 1) check("abort_rst_next_data", 32'(rx_q[0]), 32'h3C);

    // Break: line held low for several frames yields one framing error
    clear_obs();
    I_baud_div = 8'd7;
    swo = 1'b0;
    tick(200);
    swo = 1'b1;
    tick(10);
    check("break_fe", 32'(fe_cnt), 32'h1);
    check("break_nbytes", 32'(rx_q.size()), 32'h0);

    // Randomized frames against an expected-byte queue
    clear_obs();
    exp_q.delete();
    exp_fe = 0;
    for (int n = 0; n < 40; n++) begin
      int d;
      logic [7:0] b;
      logic sb;
      int gap;
      d  = $urandom_range(0, 20);
      b  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      if (sb) exp_q.push_back(b);
      else exp_fe++;
      send_frame(b, sb, d);
      // After a low stop bit the line must be seen high before a new start.
      gap = sb ? $urandom_range(0, 12) : (deff(d) + 1 + $urandom_range(0, 12));
      tick(gap);
    end
    tick(50);
    check("rand_nbytes", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      check($sformatf("rand_byte%0d", k), 32'(rx_q[k]), 32'(exp_q[k]));
    end
    check("rand_fe", 32'(fe_cnt), 32'(exp_fe));
    check("rand_ovr", 32'(ov_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
